scope_cmd_parser: RTL and testbench

Byte-level command decoder between the UART receiver and the scope/trigger control logic in `soc_top`. It consumes received bytes, decodes one-byte opcodes and fixed-length payload commands, and produces single-cycle control strobes and atomically updated trigger configuration registers. It also returns a one-byte status response to the UART transmitter. Host software drives the scope through this block alone.

---
 rtl/scope_cmd_parser.sv | 164 ++++++++++++++++
 tb/tb_scope_cmd_parser.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/scope_cmd_parser.sv
// Byte-level command decoder for the scope: turns UART bytes into control strobes,
// atomically updated trigger configuration and a one-byte status response.
module scope_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned PAYLOAD_BYTES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        scope_armed,
  input  logic        scope_triggered,
  input  logic        scope_busy,
  output logic        arm_pulse,
  output logic        disarm_pulse,
  output logic        trig_cfg_valid,
  output logic        trig_rising,
  output logic [39:0] trig_mask,
  output logic [39:0] trig_value,
  output logic        cmd_error
);

  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] LastByte = 4'(PAYLOAD_BYTES - 1);

  typedef enum logic [1:0] {StIdle, StPayload, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        byte_cnt_q, byte_cnt_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [79:0]       shadow_q, shadow_d;
  logic              edge_q, edge_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              arm_q, arm_d;
  logic              disarm_q, disarm_d;
  logic              cfg_valid_q, cfg_valid_d;
  logic              err_q, err_d;
  logic              rising_q, rising_d;
  logic [39:0]       mask_q, mask_d;
  logic [39:0]       value_q, value_d;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    tmo_d       = tmo_q;
    shadow_d    = shadow_q;
    edge_d      = edge_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    arm_d       = 1'b0;
    disarm_d    = 1'b0;
    cfg_valid_d = 1'b0;
    err_d       = 1'b0;
    rising_d    = rising_q;
    mask_d      = mask_q;
    value_d     = value_q;

    unique case (state_q)
      StIdle: begin
        if (rx_valid) begin
          case (rx_data)
            8'h41: arm_d = 1'b1;
            8'h53: disarm_d = 1'b1;
            8'h52, 8'h46: begin
              edge_d     = (rx_data == 8'h52);
              byte_cnt_d = '0;
              tmo_d      = '0;
              shadow_d   = '0;
              state_d    = StPayload;
            end
            8'h3F: begin
              // Status is snapshotted here and held for the whole response.
              tx_data_d  = {4'hA, 1'b0, scope_triggered, scope_armed, scope_busy};
              tx_valid_d = 1'b1;
              state_d    = StResp;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      StPayload: begin
        if (rx_valid) begin
          shadow_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
          tmo_d      = '0;
          byte_cnt_d = byte_cnt_q + 4'd1;
          if (byte_cnt_q == LastByte) begin
            rising_d    = edge_q;
            mask_d      = shadow_d[39:0];
            value_d     = shadow_d[79:40];
            cfg_valid_d = 1'b1;
            byte_cnt_d  = '0;
            state_d     = StIdle;
          end
        end else if (tmo_q == TmoLast) begin
          // Abort without touching the live trigger registers.
          err_d      = 1'b1;
          tmo_d      = '0;
          byte_cnt_d = '0;
          state_d    = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StResp: begin
        if (rx_valid) err_d = 1'b1;
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      byte_cnt_q  <= '0;
      tmo_q       <= '0;
      shadow_q    <= '0;
      edge_q      <= 1'b1;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      arm_q       <= 1'b0;
      disarm_q    <= 1'b0;
      cfg_valid_q <= 1'b0;
      err_q       <= 1'b0;
      rising_q    <= 1'b1;
      mask_q      <= '0;
      value_q     <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      tmo_q       <= tmo_d;
      shadow_q    <= shadow_d;
      edge_q      <= edge_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      arm_q       <= arm_d;
      disarm_q    <= disarm_d;
      cfg_valid_q <= cfg_valid_d;
      err_q       <= err_d;
      rising_q    <= rising_d;
      mask_q      <= mask_d;
      value_q     <= value_d;
    end
  end

  assign tx_data        = tx_data_q;
  assign tx_valid       = tx_valid_q;
  assign arm_pulse      = arm_q;
  assign disarm_pulse   = disarm_q;
  assign trig_cfg_valid = cfg_valid_q;
  assign trig_rising    = rising_q;
  assign trig_mask      = mask_q;
  assign trig_value     = value_q;
  assign cmd_error      = err_q;

endmodule

// File: tb/tb_scope_cmd_parser.sv
// Directed bench for scope_cmd_parser: single-byte opcode table plus hand-written
// sequences for payload, timeout, status handshake and mid-command reset.
module tb_scope_cmd_parser;

  localparam int unsigned Tmo = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        scope_armed = 1'b0;
  logic        scope_triggered = 1'b0;
  logic        scope_busy = 1'b0;
  logic        arm_pulse, disarm_pulse, trig_cfg_valid, trig_rising, cmd_error;
  logic [39:0] trig_mask, trig_value;

  int checks = 0;
  int errors = 0;
  logic [39:0] last_mask, last_value;
  logic        last_rising;

  scope_cmd_parser #(.TIMEOUT_CYCLES(Tmo), .PAYLOAD_BYTES(10)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .scope_armed(scope_armed), .scope_triggered(scope_triggered), .scope_busy(scope_busy),
    .arm_pulse(arm_pulse), .disarm_pulse(disarm_pulse), .trig_cfg_valid(trig_cfg_valid),
    .trig_rising(trig_rising), .trig_mask(trig_mask), .trig_value(trig_value),
    .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       arm;
    logic       disarm;
    logic       err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_data"}, 80'(tx_data), 80'h00);
    chk({tag, "_tx_valid"}, 80'(tx_valid), 80'h0);
    chk({tag, "_strobes"}, 80'({arm_pulse, disarm_pulse, trig_cfg_valid, cmd_error}), 80'h0);
    chk({tag, "_rising"}, 80'(trig_rising), 80'h1);
    chk({tag, "_mask"}, 80'(trig_mask), 80'h0);
    chk({tag, "_value"}, 80'(trig_value), 80'h0);
  endtask

  task automatic send_cfg(input string tag, input logic [7:0] op, input logic [79:0] p);
    int bad = 0;
    send_byte(op);
    if (arm_pulse || tx_valid || cmd_error || trig_cfg_valid) bad++;
    for (int i = 0; i < 10; i++) begin
      send_byte(p[8*i +: 8]);
      if (arm_pulse || disarm_pulse || tx_valid || cmd_error) bad++;
      if (i < 9 && trig_cfg_valid) bad++;
    end
    chk({tag, "_side_effects"}, 80'(bad), 80'h0);
    chk({tag, "_cfg_valid"}, 80'(trig_cfg_valid), 80'h1);
    chk({tag, "_mask"}, 80'(trig_mask), 80'(p[39:0]));
    chk({tag, "_value"}, 80'(trig_value), 80'(p[79:40]));
    chk({tag, "_rising"}, 80'(trig_rising), 80'(op == 8'h52));
    last_mask   = p[39:0];
    last_value  = p[79:40];
    last_rising = (op == 8'h52);
    @(negedge clk);
    chk({tag, "_cfg_valid_1cyc"}, 80'(trig_cfg_valid), 80'h0);
  endtask

  initial begin
    int err_seen;
    vecs[0] = '{data: 8'h41, arm: 1'b1, disarm: 1'b0, err: 1'b0};
    vecs[1] = '{data: 8'h53, arm: 1'b0, disarm: 1'b1, err: 1'b0};
    vecs[2] = '{data: 8'h77, arm: 1'b0, disarm: 1'b0, err: 1'b1};
    vecs[3] = '{data: 8'h00, arm: 1'b0, disarm: 1'b0, err: 1'b1};
    vecs[4] = '{data: 8'hFF, arm: 1'b0, disarm: 1'b0, err: 1'b1};
    vecs[5] = '{data: 8'h41, arm: 1'b1, disarm: 1'b0, err: 1'b0};

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      send_byte(vecs[i].data);
      chk($sformatf("vec%0d_strobes", i),
          80'({arm_pulse, disarm_pulse, cmd_error, trig_cfg_valid, tx_valid}),
          80'({vecs[i].arm, vecs[i].disarm, vecs[i].err, 1'b0, 1'b0}));
      @(negedge clk);
      chk($sformatf("vec%0d_one_cycle", i),
          80'({arm_pulse, disarm_pulse, cmd_error}), 80'h0);
    end

    send_cfg("rise", 8'h52, 80'h09080706050403020100);
    chk("rise_mask_const", 80'(trig_mask), 80'h0403020100);
    chk("rise_value_const", 80'(trig_value), 80'h0908070605);
    send_cfg("fall", 8'h46, 80'h09080706050403020100);
    chk("fall_rising_const", 80'(trig_rising), 80'h0);
    send_cfg("opc_in_payload", 8'h52, 80'h7060503F413020103F41);

    // Timeout after 4 payload bytes: abort exactly Tmo idle cycles later.
    send_byte(8'h52);
    for (int i = 0; i < 4; i++) send_byte(8'hE0 + 8'(i));
    err_seen = 0;
    for (int i = 1; i <= int'(Tmo); i++) begin
      @(negedge clk);
      if (cmd_error && err_seen == 0) err_seen = i;
    end
    chk("timeout_cycle", 80'(err_seen), 80'(Tmo));
    chk("timeout_mask_kept", 80'(trig_mask), 80'(last_mask));
    chk("timeout_value_kept", 80'(trig_value), 80'(last_value));
    chk("timeout_rising_kept", 80'(trig_rising), 80'(last_rising));
    @(negedge clk);
    chk("timeout_err_1cyc", 80'(cmd_error), 80'h0);
    send_byte(8'h41);
    chk("arm_after_timeout", 80'(arm_pulse), 80'h1);

    // A byte arriving exactly at the limit is accepted.
    send_byte(8'h46);
    err_seen = 0;
    repeat (Tmo - 1) begin
      @(negedge clk);
      if (cmd_error) err_seen++;
    end
    send_byte(8'h11);
    if (cmd_error) err_seen++;
    chk("limit_no_timeout", 80'(err_seen), 80'h0);
    for (int i = 1; i < 10; i++) send_byte(8'h11 * 8'(i + 1));
    chk("limit_cfg_valid", 80'(trig_cfg_valid), 80'h1);
    chk("limit_mask", 80'(trig_mask), 80'h5544332211);
    chk("limit_value", 80'(trig_value), 80'hAA99887766);
    chk("limit_rising", 80'(trig_rising), 80'h0);

    // Status response held while tx_ready is low; opcode during it is an error.
    scope_armed = 1'b1;
    scope_triggered = 1'b1;
    scope_busy = 1'b0;
    @(negedge clk);
    send_byte(8'h3F);
    chk("stat_tx_valid", 80'(tx_valid), 80'h1);
    chk("stat_tx_data", 80'(tx_data), 80'hA6);
    err_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) scope_busy = 1'b1;
      if (i == 5) begin
        send_byte(8'h41);
        chk("resp_rx_err", 80'(cmd_error), 80'h1);
        chk("resp_rx_no_arm", 80'(arm_pulse), 80'h0);
      end else begin
        @(negedge clk);
      end
      if (!tx_valid || tx_data !== 8'hA6) err_seen++;
    end
    chk("stat_held_stable", 80'(err_seen), 80'h0);
    tx_ready = 1'b1;
    @(negedge clk);
    chk("stat_tx_drop", 80'(tx_valid), 80'h0);
    tx_ready = 1'b0;
    scope_armed = 1'b0;
    scope_triggered = 1'b0;
    scope_busy = 1'b0;

    // Reset mid-payload, then a fresh command completes normally.
    send_byte(8'h52);
    for (int i = 0; i < 6; i++) send_byte(8'h41);
    rst_n = 1'b0;
    #2;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h41);
    chk("midrst_byte_is_opcode", 80'(arm_pulse), 80'h1);
    send_cfg("post_rst", 8'h46, 80'hC3B2A1F0E5D4C3B2A190);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
